// File: rtl/svc_rv_fetch.sv
// svc_rv_fetch: instruction fetch stage in front of a synchronous-read
// instruction memory. Owns the PC, drives the memory enable/address, and
// pairs each returned word with the PC it was fetched from.
//
// Optional feature: define SVC_RV_FETCH_PERF_EN to add the perf_fetch_cnt /
// perf_stall_cnt counter outputs. Without it the ports do not exist.
//
// Handshake (out_*): a beat transfers on a cycle where out_valid & out_ready.
// Once out_valid is high, out_pc/out_instr stay stable until accepted, unless
// a redirect squashes the beat. out_valid never depends on out_ready.
// A redirect cycle always forces out_valid low, so a squashed beat can never
// be accepted.
//
// Stall is implemented by dropping imem_en: the memory output register holds
// the pending word, so no skid buffer is needed.
module svc_rv_fetch #(
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_data,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr
`ifdef SVC_RV_FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  // Next PC to fetch, in-flight/held flag, and PC of the word in imem_data.
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        vld_q;
  logic        vld_d;
  logic [31:0] pc_d_q;
  logic [31:0] pc_d_d;

  logic        advance;
  logic [31:0] fpc;

  // Fetch address selection, memory control and beat presentation.
  always_comb begin
    advance   = ~vld_q | out_ready | redirect_valid;
    // Misaligned redirect targets are word-aligned by clearing bits [1:0].
    fpc       = redirect_valid ? (redirect_pc & ~32'h0000_0003) : pc_q;
    imem_en   = advance & ~rst;
    imem_addr = fpc[AW+1:2];
    out_valid = vld_q & ~redirect_valid & ~rst;
    out_pc    = pc_d_q;
    out_instr = imem_data;
  end

  // Next-state: on advance, launch a read at fpc; otherwise hold everything.
  always_comb begin
    pc_d   = pc_q;
    vld_d  = vld_q;
    pc_d_d = pc_d_q;
    if (advance) begin
      pc_d   = fpc + 32'd4;
      vld_d  = 1'b1;
      pc_d_d = fpc;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      vld_q  <= 1'b0;
      pc_d_q <= 32'h0000_0000;
    end else begin
      pc_q   <= pc_d;
      vld_q  <= vld_d;
      pc_d_q <= pc_d_d;
    end
  end

`ifdef SVC_RV_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count accepted beats and cycles where a valid beat is back-pressured.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid & out_ready)  fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (out_valid & ~out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
